pll_lock_supervisor: RTL

Lock supervisor and reset sequencer that sits on the consumer side of the ADC-test clock PLL (50 MHz reference in, 10 MHz out). It drives the PLL reset, watches the PLL `locked` output, and holds downstream ADC logic in reset until lock has been continuously stable. On lock loss or lock timeout it re-runs the PLL reset sequence and counts the event for debug.

---
 rtl/pll_sup_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/pll_lock_supervisor.sv | 98 +++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared state encoding, default parameters and sizing helper for the PLL lock supervisor
package pll_sup_pkg;

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_sup_state_t;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 50000;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_CNT_W         = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer with synchronous active-low clear
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first stage a full cycle to resolve
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: PLL reset sequencer that releases downstream reset only after lock is stable
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             locked,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             up,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] loss_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    localparam int CW = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);

    localparam logic [1:0] S_RESET  = RESET_PLL;
    localparam logic [1:0] S_WAIT   = WAIT_LOCK;
    localparam logic [1:0] S_STABLE = STABLE;
    localparam logic [1:0] S_RUN    = RUN;

    logic [1:0]    state;
    logic [1:0]    nxt;
    logic [CW-1:0] cnt;
    logic          lk;
    logic          sync_rst_n;
    logic          rst_done;
    logic          wait_expired;
    logic          stable_done;
    logic          timeout_ev;
    logic          loss_ev;

    // The PLL's lock output is meaningless while it is held in reset, so the
    // synchronizer is cleared then and lock must be re-seen after release.
    assign sync_rst_n = rst_n & ~pll_rst;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (sync_rst_n),
        .d     (locked),
        .q     (lk)
    );

    assign rst_done     = cnt == CW'(RST_CYCLES - 1);
    assign wait_expired = cnt == CW'(LOCK_TIMEOUT - 1);
    assign stable_done  = cnt == CW'(STABLE_CYCLES - 1);
    assign timeout_ev   = (state == S_WAIT) && !lk && wait_expired;
    assign loss_ev      = (state == S_RUN) && !lk;
    assign state_o      = state;

    // Next-state decision; lock takes priority over an expiring wait timer
    always_comb begin
        nxt = state;
        case (state)
            S_RESET:  nxt = rst_done ? S_WAIT : S_RESET;
            S_WAIT:   nxt = lk ? S_STABLE : (wait_expired ? S_RESET : S_WAIT);
            S_STABLE: nxt = !lk ? S_WAIT : (stable_done ? S_RUN : S_STABLE);
            default:  nxt = lk ? S_RUN : S_RESET;
        endcase
    end

    // State, shared cycle counter and registered reset/status outputs
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state     <= S_RESET;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            up        <= 1'b0;
        end else begin
            state     <= nxt;
            cnt       <= (nxt != state || state == S_RUN) ? '0 : cnt + 1'b1;
            pll_rst   <= nxt == S_RESET;
            sys_rst_n <= nxt == S_RUN;
            up        <= nxt == S_RUN;
        end
    end

    // Saturating debug counters for lock losses in RUN and lock-wait timeouts
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            loss_cnt    <= '0;
            timeout_cnt <= '0;
        end else begin
            if (loss_ev && loss_cnt != '1)
                loss_cnt <= loss_cnt + 1'b1;
            if (timeout_ev && timeout_cnt != '1)
                timeout_cnt <= timeout_cnt + 1'b1;
        end
    end

endmodule
